// File: rtl/counter_controller.sv
// Start/stop/hold counter with captured terminal count, one-shot DONE or free-run WRAP pulses.
// Optional macro COUNTER_CONTROLLER_PRESCALE_EN: ticks only every 4th CLK in RUN.
module counter_controller #(
  parameter int WIDTH = 3
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             STOP,
  input  logic             CLEAR,
  input  logic             ONE_SHOT,
  input  logic [WIDTH-1:0] LIMIT,
  output logic [WIDTH-1:0] Q,
  output logic             BUSY,
  output logic             DONE,
  output logic             WRAP
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] lim_q, lim_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             wrap_q, wrap_d;
  logic             tick;

`ifdef COUNTER_CONTROLLER_PRESCALE_EN
  logic [1:0] pre_q, pre_d;

  // Prescaler only advances on RUN cycles that are not being paused.
  always_comb begin
    pre_d = pre_q;
    if (CLEAR) begin
      pre_d = '0;
    end else if ((state_q == S_IDLE || state_q == S_DONE) && START) begin
      pre_d = '0;
    end else if (state_q == S_RUN && !STOP) begin
      pre_d = pre_q + 2'd1;
    end
  end

  assign tick = (pre_q == 2'd3);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lim_d   = lim_q;
    done_d  = 1'b0;
    wrap_d  = 1'b0;
    if (CLEAR) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (START) begin
            state_d = S_RUN;
            cnt_d   = '0;
            lim_d   = LIMIT;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_RUN: begin
          if (STOP) begin
            state_d = S_HOLD;
          end else if (tick) begin
            if (cnt_q != lim_q) begin
              cnt_d = cnt_q + WIDTH'(1);
            end else if (ONE_SHOT) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              cnt_d  = '0;
              wrap_d = 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (START && !STOP) begin
            state_d = S_RUN;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = (state_d == S_RUN) || (state_d == S_HOLD);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      lim_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lim_q   <= lim_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end

  assign Q    = cnt_q;
  assign BUSY = busy_q;
  assign DONE = done_q;
  assign WRAP = wrap_q;

endmodule

// File: tb/tb_counter_controller.sv
// Bench for counter_controller: behavioural model compared every cycle, directed literal checks, random phase.
module tb_counter_controller;

  localparam int W = 3;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b1;
  logic         START, STOP, CLEAR, ONE_SHOT;
  logic [W-1:0] LIMIT;
  logic [W-1:0] Q;
  logic         BUSY, DONE, WRAP;

  counter_controller #(.WIDTH(W)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .STOP(STOP), .CLEAR(CLEAR),
    .ONE_SHOT(ONE_SHOT), .LIMIT(LIMIT), .Q(Q), .BUSY(BUSY), .DONE(DONE), .WRAP(WRAP)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: operating mode, count, captured limit, and RUN-cycle phase.
  typedef enum int {M_IDLE, M_RUN, M_HOLD, M_FIN} mode_t;
  mode_t m_st   = M_IDLE;
  int    m_q    = 0;
  int    m_lim  = 0;
  int    m_pre  = 0;
  int    m_done = 0;
  int    m_wrap = 0;

  always @(posedge CLK or negedge RST_N) begin
    bit tick_now;
    if (!RST_N) begin
      m_st = M_IDLE; m_q = 0; m_lim = 0; m_pre = 0; m_done = 0; m_wrap = 0;
    end else begin
      m_done = 0;
      m_wrap = 0;
      if (CLEAR) begin
        m_st = M_IDLE; m_q = 0; m_pre = 0;
      end else if (m_st == M_IDLE || m_st == M_FIN) begin
        if (START) begin
          m_st = M_RUN; m_q = 0; m_lim = int'(LIMIT); m_pre = 0;
        end else begin
          m_st = M_IDLE;
        end
      end else if (m_st == M_RUN) begin
        if (STOP) begin
          m_st = M_HOLD;
        end else begin
`ifdef COUNTER_CONTROLLER_PRESCALE_EN
          m_pre    = (m_pre + 1) % 4;
          tick_now = (m_pre == 0);
`else
          tick_now = 1'b1;
`endif
          if (tick_now) begin
            if (m_q < m_lim) m_q = m_q + 1;
            else if (ONE_SHOT) begin m_st = M_FIN; m_done = 1; end
            else begin m_q = 0; m_wrap = 1; end
          end
        end
      end else if (START && !STOP) begin
        m_st = M_RUN;
      end
    end
  end

  always @(negedge CLK) begin
    if (mon_en) begin
      chk("model_q",    int'(Q),    m_q);
      chk("model_busy", int'(BUSY), (m_st == M_RUN || m_st == M_HOLD) ? 1 : 0);
      chk("model_done", int'(DONE), m_done);
      chk("model_wrap", int'(WRAP), m_wrap);
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic go(input int lim, input bit os);
    LIMIT = W'(lim); ONE_SHOT = os; START = 1'b1;
    cyc();
    START = 1'b0;
  endtask

  initial begin
    START = 0; STOP = 0; CLEAR = 0; ONE_SHOT = 0; LIMIT = '0;
    #2 RST_N = 1'b0;
    #1;
    chk("reset_q", int'(Q), 0);
    chk("reset_busy", int'(BUSY), 0);
    chk("reset_done", int'(DONE), 0);
    chk("reset_wrap", int'(WRAP), 0);
    cyc(2);
    RST_N  = 1'b1;
    mon_en = 1'b1;
    cyc();

`ifndef COUNTER_CONTROLLER_PRESCALE_EN
    // One-shot to 5
    go(5, 1);
    chk("os5_q0", int'(Q), 0);
    chk("os5_busy", int'(BUSY), 1);
    for (int i = 1; i <= 5; i++) begin cyc(); chk("os5_q", int'(Q), i); end
    cyc();
    chk("os5_done", int'(DONE), 1);
    chk("os5_qhold", int'(Q), 5);
    cyc();
    chk("os5_done_clr", int'(DONE), 0);
    chk("os5_idle_busy", int'(BUSY), 0);
    chk("os5_idle_q", int'(Q), 5);

    // Free-run limit 2
    go(2, 0);
    for (int i = 1; i <= 6; i++) begin
      cyc();
      chk("fr2_q", int'(Q), i % 3);
      chk("fr2_wrap", int'(WRAP), (i % 3 == 0) ? 1 : 0);
      chk("fr2_busy", int'(BUSY), 1);
    end
    CLEAR = 1; cyc(); CLEAR = 0;
    chk("clr_q", int'(Q), 0);
    chk("clr_busy", int'(BUSY), 0);

    // Pause at 3 for 4 cycles, then resume to 7
    go(7, 1);
    cyc(3);
    chk("hold_pre_q", int'(Q), 3);
    STOP = 1;
    repeat (4) begin cyc(); chk("hold_q", int'(Q), 3); chk("hold_busy", int'(BUSY), 1); end
    STOP = 0; START = 1; cyc(); START = 0;
    chk("resume_q", int'(Q), 3);
    for (int v = 4; v <= 7; v++) begin cyc(); chk("resume_cnt", int'(Q), v); end
    cyc();
    chk("resume_done", int'(DONE), 1);
    chk("resume_done_q", int'(Q), 7);
    cyc();

    // All commands at once, then asynchronous reset mid-cycle
    go(7, 1);
    cyc(4);
    chk("prio_pre_q", int'(Q), 4);
    START = 1; STOP = 1; CLEAR = 1; cyc(); START = 0; STOP = 0; CLEAR = 0;
    chk("prio_q", int'(Q), 0);
    chk("prio_busy", int'(BUSY), 0);
    go(7, 1);
    cyc(2);
    #2 RST_N = 1'b0;
    #1;
    chk("arst_q", int'(Q), 0);
    chk("arst_busy", int'(BUSY), 0);
    RST_N = 1'b1;
    cyc(2);
    chk("arst_stay_q", int'(Q), 0);
    chk("arst_stay_busy", int'(BUSY), 0);

    // Limit 0, and LIMIT changes after capture
    go(0, 1);
    chk("lim0_busy", int'(BUSY), 1);
    cyc();
    chk("lim0_done", int'(DONE), 1);
    chk("lim0_q", int'(Q), 0);
    go(0, 0);
    for (int i = 0; i < 3; i++) begin cyc(); chk("lim0_wrap", int'(WRAP), 1); chk("lim0_fr_q", int'(Q), 0); end
    CLEAR = 1; cyc(); CLEAR = 0;
    go(3, 1);
    LIMIT = 3'd6;
    for (int v = 1; v <= 3; v++) begin cyc(); chk("limchg_q", int'(Q), v); end
    cyc();
    chk("limchg_done", int'(DONE), 1);
    chk("limchg_qhold", int'(Q), 3);
    cyc();
`else
    // Prescaled one-shot to 1: Q steps every 4 CLK, DONE 8 CLK after entering RUN
    go(1, 1);
    for (int i = 1; i <= 8; i++) begin
      cyc();
      chk("pre_q", int'(Q), (i >= 4) ? 1 : 0);
      chk("pre_done", int'(DONE), (i == 8) ? 1 : 0);
    end
    cyc();
`endif

    // Random phase
    for (int i = 0; i < 1500; i++) begin
      CLEAR    = ($urandom_range(19) == 0);
      STOP     = ($urandom_range(5) == 0);
      START    = ($urandom_range(3) == 0);
      ONE_SHOT = ($urandom_range(1) == 1);
      LIMIT    = W'($urandom_range(7));
      if ($urandom_range(199) == 0) begin
        RST_N = 1'b0;
        cyc();
        RST_N = 1'b1;
      end else begin
        cyc();
      end
    end

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
